// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: control FSM for the MM:SS.cc stopwatch counter chain.
//
// Debounces the three active-low KEY pushbuttons, sequences IDLE/RUN/LAP/STOP, generates the
// gated 100 Hz Tick count enable and the one-cycle Clear/Load strobes plus the Freeze level
// for the digit counters and display registers.
//
// Parameters:
//   TICK_DIV  - clock cycles per Tick
//   TICK_W    - prescaler width, 2**TICK_W >= TICK_DIV
//   DB_CYCLES - cycles a synced key must hold a new level before it is accepted
//   DB_W      - debounce counter width, 2**DB_W >= DB_CYCLES
//
// Ports:
//   Clock     in   system clock
//   Resetn    in   asynchronous active-low reset
//   KeyStart  in   raw active-low Start/Stop button
//   KeyLap    in   raw active-low Lap / clear-when-stopped button
//   KeyLoad   in   raw active-low preset-load button
//   Wrap      in   rollover strobe from the deca-minutes counter
//   Run       out  1 in RUN or LAP
//   Tick      out  one-cycle count enable to the centisecond counter
//   Clear     out  one-cycle synchronous clear to all digit counters
//   Load      out  one-cycle load strobe to the minute counters
//   Freeze    out  1 = display registers hold the lap value
//   State     out  00 IDLE, 01 RUN, 10 LAP, 11 STOP
//
// Build option: define STOPWATCH_CTRL_AUTOSTOP_EN to stop the watch when Wrap fires while
// running; otherwise Wrap is ignored and the time wraps freely.

module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV  = 500000,
  parameter int unsigned TICK_W    = 19,
  parameter int unsigned DB_CYCLES = 1000000,
  parameter int unsigned DB_W      = 20
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       KeyStart,
  input  logic       KeyLap,
  input  logic       KeyLoad,
  input  logic       Wrap,
  output logic       Run,
  output logic       Tick,
  output logic       Clear,
  output logic       Load,
  output logic       Freeze,
  output logic [1:0] State
);

  localparam logic [1:0] StIdle = 2'b00;
  localparam logic [1:0] StRun  = 2'b01;
  localparam logic [1:0] StLap  = 2'b10;
  localparam logic [1:0] StStop = 2'b11;

  localparam logic [DB_W-1:0]   DbLast   = DB_W'(DB_CYCLES - 1);
  localparam logic [TICK_W-1:0] TickLast = TICK_W'(TICK_DIV - 1);

  // Key index: 0 = Start, 1 = Lap, 2 = Load
  logic [2:0]      sync1_q, sync2_q;
  logic [2:0]      db_q, db_d;
  logic [2:0]      armed_q, armed_d;
  logic [2:0]      evt_q, evt_d;
  logic [DB_W-1:0] cnt_q [3];
  logic [DB_W-1:0] cnt_d [3];
  logic [1:0]      startup_q, startup_d;

  logic [1:0]        state_q, state_d;
  logic              run_q, run_d;
  logic              tick_q, tick_d;
  logic              clear_q, clear_d;
  logic              load_q, load_d;
  logic              freeze_q, freeze_d;
  logic [TICK_W-1:0] presc_q, presc_d;
  logic              stop_on_wrap;

  logic ev_start, ev_lap, ev_load;
  assign ev_start = evt_q[0];
  assign ev_lap   = evt_q[1];
  assign ev_load  = evt_q[2];

  // Debounce and press detection. A key only produces events once it has been seen released
  // after reset (armed), so a button held through reset needs a release and a fresh press.
  always_comb begin
    // startup_q[1] marks the synchronizer as carrying real samples rather than reset values
    startup_d = {startup_q[0], 1'b1};
    for (int i = 0; i < 3; i++) begin
      db_d[i]  = db_q[i];
      cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == DbLast) begin
          db_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DB_W'(1);
        end
      end
      armed_d[i] = armed_q[i] | (startup_q[1] & sync2_q[i] & db_q[i]);
      evt_d[i]   = armed_q[i] & db_q[i] & ~db_d[i];
    end
  end

`ifdef STOPWATCH_CTRL_AUTOSTOP_EN
  assign stop_on_wrap = Wrap & run_q;
`else
  logic unused_wrap;
  assign unused_wrap  = Wrap;
  assign stop_on_wrap = 1'b0;
`endif

  // Sequencing. Event priority Start > Lap > Load; lower-priority events are dropped.
  always_comb begin
    state_d  = state_q;
    freeze_d = freeze_q;
    clear_d  = 1'b0;
    load_d   = 1'b0;
    if (stop_on_wrap) begin
      state_d  = StStop;
      freeze_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ev_start) begin
            state_d = StRun;
          end else if (ev_load) begin
            load_d = 1'b1;
          end
        end
        StRun: begin
          if (ev_start) begin
            state_d = StStop;
          end else if (ev_lap) begin
            state_d  = StLap;
            freeze_d = 1'b1;
          end
        end
        StLap: begin
          if (ev_start) begin
            state_d  = StStop;
            freeze_d = 1'b0;
          end else if (ev_lap) begin
            state_d  = StRun;
            freeze_d = 1'b0;
          end
        end
        StStop: begin
          if (ev_start) begin
            state_d = StRun;
          end else if (ev_lap) begin
            state_d = StIdle;
            clear_d = 1'b1;
          end else if (ev_load) begin
            load_d = 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
    run_d = (state_d == StRun) || (state_d == StLap);
  end

  // Prescaler. Holds in STOP so a resumed run keeps the partial centisecond.
  always_comb begin
    presc_d = presc_q;
    tick_d  = 1'b0;
    if ((state_q == StIdle) || clear_d) begin
      presc_d = '0;
    end else if (run_q && !stop_on_wrap) begin
      if (presc_q == TickLast) begin
        presc_d = '0;
        tick_d  = 1'b1;
      end else begin
        presc_d = presc_q + TICK_W'(1);
      end
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      sync1_q   <= 3'b111;
      sync2_q   <= 3'b111;
      db_q      <= 3'b111;
      armed_q   <= 3'b000;
      evt_q     <= 3'b000;
      startup_q <= 2'b00;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= '0;
      end
      state_q  <= StIdle;
      run_q    <= 1'b0;
      tick_q   <= 1'b0;
      clear_q  <= 1'b0;
      load_q   <= 1'b0;
      freeze_q <= 1'b0;
      presc_q  <= '0;
    end else begin
      sync1_q   <= {KeyLoad, KeyLap, KeyStart};
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      armed_q   <= armed_d;
      evt_q     <= evt_d;
      startup_q <= startup_d;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      state_q  <= state_d;
      run_q    <= run_d;
      tick_q   <= tick_d;
      clear_q  <= clear_d;
      load_q   <= load_d;
      freeze_q <= freeze_d;
      presc_q  <= presc_d;
    end
  end

  assign Run    = run_q;
  assign Tick   = tick_q;
  assign Clear  = clear_q;
  assign Load   = load_q;
  assign Freeze = freeze_q;
  assign State  = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl with DB_CYCLES=4, TICK_DIV=5.
// Cycle N is the interval after the N-th rising clock edge. A key driven low in cycle k
// produces its state change in cycle k+7.

module tb_stopwatch_ctrl;

  localparam int KStatus = 0;
  localparam int KTick   = 1;
  localparam int KClear  = 2;
  localparam int KLoad   = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic key_start = 1'b1;
  logic key_lap = 1'b1;
  logic key_load = 1'b1;
  logic wrap = 1'b0;
  logic run, tick, clear, load, freeze;
  logic [1:0] state;

  stopwatch_ctrl #(
    .TICK_DIV (5),
    .TICK_W   (3),
    .DB_CYCLES(4),
    .DB_W     (3)
  ) dut (
    .Clock   (clk),
    .Resetn  (rst_n),
    .KeyStart(key_start),
    .KeyLap  (key_lap),
    .KeyLoad (key_load),
    .Wrap    (wrap),
    .Run     (run),
    .Tick    (tick),
    .Clear   (clear),
    .Load    (load),
    .Freeze  (freeze),
    .State   (state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    int         cyc;
    int         kind;
    logic [1:0] st;
    logic       fr;
    logic       rn;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Insert keeping the queue ordered by (cycle, kind), the order the monitor reports in.
  function automatic void push_exp(int c, int kind, logic [1:0] st, logic fr, logic rn);
    exp_t e;
    int pos;
    e.cyc  = c;
    e.kind = kind;
    e.st   = st;
    e.fr   = fr;
    e.rn   = rn;
    pos = exp_q.size();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].cyc > c || (exp_q[i].cyc == c && exp_q[i].kind > kind)) begin
        pos = i;
        break;
      end
    end
    exp_q.insert(pos, e);
  endfunction

  function automatic void push_ticks(int first, int last);
    for (int t = first; t <= last; t += 5) push_exp(t, KTick, 2'b00, 1'b0, 1'b0);
  endfunction

  task automatic observe(int kind);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind=%0d at cycle %0d (state=%b freeze=%b run=%b), required none",
               kind, cyc, state, freeze, run);
    end else begin
      e = exp_q.pop_front();
      if (e.cyc != cyc || e.kind != kind ||
          (kind == KStatus && {e.st, e.fr, e.rn} != {state, freeze, run})) begin
        errors++;
        $display("FAIL event_match: got kind=%0d cycle=%0d state=%b freeze=%b run=%b, required kind=%0d cycle=%0d state=%b freeze=%b run=%b",
                 kind, cyc, state, freeze, run, e.kind, e.cyc, e.st, e.fr, e.rn);
      end
    end
  endtask

  // Monitor: reports status changes and every strobe, sampled mid-cycle.
  logic [3:0] prev_status = 4'b0000;
  always @(negedge clk) begin
    if ({state, freeze, run} != prev_status) observe(KStatus);
    if (tick)  observe(KTick);
    if (clear) observe(KClear);
    if (load)  observe(KLoad);
    prev_status <= {state, freeze, run};
  end

  task automatic check(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  task automatic at_cycle(int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_key(int which, logic val);
    case (which)
      0:       key_start = val;
      1:       key_lap   = val;
      default: key_load  = val;
    endcase
  endtask

  task automatic press(int which, int k, int hold);
    at_cycle(k);
    set_key(which, 1'b0);
    at_cycle(k + hold);
    set_key(which, 1'b1);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    at_cycle(1);
    check("reset_run", run, 0);
    check("reset_tick", tick, 0);
    check("reset_clear", clear, 0);
    check("reset_load", load, 0);
    check("reset_freeze", freeze, 0);
    check("reset_state", state, 0);
    at_cycle(2);
    rst_n = 1'b1;

    // IDLE -> RUN, first Tick 5 cycles after Run rises
    push_exp(17, KStatus, 2'b01, 1'b0, 1'b1);
    push_ticks(22, 87);
    press(0, 10, 10);
    // Lap freezes, Ticks continue; Lap again unfreezes
    push_exp(37, KStatus, 2'b10, 1'b1, 1'b1);
    press(1, 30, 5);
    push_exp(57, KStatus, 2'b01, 1'b0, 1'b1);
    press(1, 50, 5);
    // Bouncing Start, stable from 82: STOP at 89 with prescaler left at 2
    push_exp(89, KStatus, 2'b11, 1'b0, 1'b0);
    at_cycle(74); key_start = 1'b0;
    at_cycle(77); key_start = 1'b1;
    at_cycle(78); key_start = 1'b0;
    at_cycle(81); key_start = 1'b1;
    at_cycle(82); key_start = 1'b0;
    at_cycle(90); key_start = 1'b1;
    // Resume: next Tick 3 cycles after Run rises
    push_exp(107, KStatus, 2'b01, 1'b0, 1'b1);
    push_ticks(110, 125);
    press(0, 100, 5);
    push_exp(127, KStatus, 2'b11, 1'b0, 1'b0);
    press(0, 120, 5);
    // Lap in STOP clears and returns to IDLE
    push_exp(147, KStatus, 2'b00, 1'b0, 1'b0);
    push_exp(147, KClear, 2'b00, 1'b0, 1'b0);
    press(1, 140, 5);
    // Load in IDLE strobes
    push_exp(167, KLoad, 2'b00, 1'b0, 1'b0);
    press(2, 160, 5);
    // Cleared prescaler: full 5-cycle wait to the first Tick
    push_exp(187, KStatus, 2'b01, 1'b0, 1'b1);
    push_ticks(192, 217);
    press(0, 180, 5);
    // Load in RUN: nothing expected
    press(2, 190, 5);
    // Start and Lap together from RUN: Start wins
    push_exp(218, KStatus, 2'b11, 1'b0, 1'b0);
    at_cycle(211); key_start = 1'b0; key_lap = 1'b0;
    at_cycle(216); key_start = 1'b1; key_lap = 1'b1;
    // Load in STOP strobes
    push_exp(237, KLoad, 2'b00, 1'b0, 1'b0);
    press(2, 230, 5);
    // Resume with prescaler at 1, then reset mid-run with Start held across it
    push_exp(257, KStatus, 2'b01, 1'b0, 1'b1);
    push_ticks(261, 271);
    press(0, 250, 5);
    push_exp(272, KStatus, 2'b00, 1'b0, 1'b0);
    at_cycle(270); key_start = 1'b0;
    at_cycle(272); rst_n = 1'b0;
    at_cycle(275); rst_n = 1'b1;
    at_cycle(300); key_start = 1'b1;
    // Fresh press after release is accepted
    push_exp(327, KStatus, 2'b01, 1'b0, 1'b1);
    push_exp(332, KTick, 2'b00, 1'b0, 1'b0);
`ifdef STOPWATCH_CTRL_AUTOSTOP_EN
    push_exp(334, KStatus, 2'b11, 1'b0, 1'b0);
`else
    push_ticks(337, 342);
`endif
    press(0, 320, 5);
    at_cycle(333); wrap = 1'b1;
    at_cycle(334); wrap = 1'b0;

    at_cycle(345);
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_event: got nothing, required kind=%0d at cycle %0d state=%b freeze=%b run=%b",
               e.kind, e.cyc, e.st, e.fr, e.rn);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
